// File: rtl/alu_result_stage.sv
// ALU result stage: two-entry skid buffer between the ALU and write-back.
// Also owns the architectural flag register and a retired-entry counter.
module alu_result_stage #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              inValid,
   output logic              inReady,
   input  logic [DATA_W-1:0] result,
   input  logic              carryFlag,
   input  logic              signFlag,
   input  logic              zeroFlag,
   input  logic [REG_W-1:0]  dstReg,
   input  logic              regWrite,
   input  logic              flagWrite,
   output logic              outValid,
   input  logic              outReady,
   output logic [DATA_W-1:0] outResult,
   output logic [REG_W-1:0]  outDst,
   output logic              outRegWrite,
   output logic [2:0]        statusFlags,
   output logic [15:0]       retireCount
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t state;

   logic              capture;
   logic              retire;

   logic [2:0]        headFlags;
   logic              headFlagWr;

   logic [DATA_W-1:0] skidResult;
   logic [REG_W-1:0]  skidDst;
   logic              skidRegWr;
   logic [2:0]        skidFlags;
   logic              skidFlagWr;

   // Handshakes; a flush cancels both sides in the same cycle
   assign capture = inValid && inReady && !flush;
   assign retire  = outValid && outReady && !flush;

   // Buffer FSM with registered handshake outputs and retire bookkeeping
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= EMPTY;
         inReady     <= 1'b0;
         outValid    <= 1'b0;
         outResult   <= '0;
         outDst      <= '0;
         outRegWrite <= 1'b0;
         headFlags   <= 3'b000;
         headFlagWr  <= 1'b0;
         skidResult  <= '0;
         skidDst     <= '0;
         skidRegWr   <= 1'b0;
         skidFlags   <= 3'b000;
         skidFlagWr  <= 1'b0;
         statusFlags <= 3'b000;
         retireCount <= 16'd0;
      end else if (flush) begin
         state    <= EMPTY;
         inReady  <= 1'b1;
         outValid <= 1'b0;
      end else begin
         unique case (state)
            EMPTY: begin
               inReady <= 1'b1;
               if (capture) begin
                  outResult   <= result;
                  outDst      <= dstReg;
                  outRegWrite <= regWrite;
                  headFlags   <= {carryFlag, signFlag, zeroFlag};
                  headFlagWr  <= flagWrite;
                  state       <= ONE;
                  outValid    <= 1'b1;
               end
            end
            ONE: begin
               if (capture && retire) begin
                  outResult   <= result;
                  outDst      <= dstReg;
                  outRegWrite <= regWrite;
                  headFlags   <= {carryFlag, signFlag, zeroFlag};
                  headFlagWr  <= flagWrite;
               end else if (capture) begin
                  skidResult <= result;
                  skidDst    <= dstReg;
                  skidRegWr  <= regWrite;
                  skidFlags  <= {carryFlag, signFlag, zeroFlag};
                  skidFlagWr <= flagWrite;
                  state      <= FULL;
                  inReady    <= 1'b0;
               end else if (retire) begin
                  state    <= EMPTY;
                  outValid <= 1'b0;
               end
            end
            FULL: begin
               if (retire) begin
                  outResult   <= skidResult;
                  outDst      <= skidDst;
                  outRegWrite <= skidRegWr;
                  headFlags   <= skidFlags;
                  headFlagWr  <= skidFlagWr;
                  state       <= ONE;
                  inReady     <= 1'b1;
               end
            end
            default: begin
               state    <= EMPTY;
               inReady  <= 1'b1;
               outValid <= 1'b0;
            end
         endcase
         if (retire) begin
            retireCount <= retireCount + 16'd1;
            if (headFlagWr) begin
               statusFlags <= headFlags;
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage.
// Inputs change 1ns after a rising edge; outputs are sampled there too.
module tb_alu_result_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        flush = 1'b0;
   logic        inValid = 1'b0;
   logic        inReady;
   logic [31:0] result = '0;
   logic        carryFlag = 1'b0;
   logic        signFlag = 1'b0;
   logic        zeroFlag = 1'b0;
   logic [4:0]  dstReg = '0;
   logic        regWrite = 1'b0;
   logic        flagWrite = 1'b0;
   logic        outValid;
   logic        outReady = 1'b0;
   logic [31:0] outResult;
   logic [4:0]  outDst;
   logic        outRegWrite;
   logic [2:0]  statusFlags;
   logic [15:0] retireCount;

   int numChk = 0;
   int numBad = 0;

   alu_result_stage #(.DATA_W(32), .REG_W(5)) dut (
      .clk(clk),
      .rst(rst),
      .flush(flush),
      .inValid(inValid),
      .inReady(inReady),
      .result(result),
      .carryFlag(carryFlag),
      .signFlag(signFlag),
      .zeroFlag(zeroFlag),
      .dstReg(dstReg),
      .regWrite(regWrite),
      .flagWrite(flagWrite),
      .outValid(outValid),
      .outReady(outReady),
      .outResult(outResult),
      .outDst(outDst),
      .outRegWrite(outRegWrite),
      .statusFlags(statusFlags),
      .retireCount(retireCount)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      numChk++;
      if (got !== exp) begin
         numBad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [31:0] r, input logic [4:0] d,
                        input logic fw, input logic [2:0] f);
      inValid   = 1'b1;
      result    = r;
      dstReg    = d;
      regWrite  = 1'b1;
      flagWrite = fw;
      {carryFlag, signFlag, zeroFlag} = f;
   endtask

   initial begin
      // reset state
      #1;
      chk("rst outValid", 32'(outValid), 0);
      chk("rst inReady", 32'(inReady), 0);
      chk("rst outResult", outResult, 0);
      chk("rst retireCount", 32'(retireCount), 0);
      chk("rst statusFlags", 32'(statusFlags), 0);
      @(negedge clk);
      rst = 1'b1;
      step();
      chk("post-rst inReady", 32'(inReady), 1);
      chk("post-rst outValid", 32'(outValid), 0);

      // single op
      outReady = 1'b1;
      offer(32'h5, 5'd3, 1'b1, 3'b000);
      step();
      inValid = 1'b0;
      chk("single outValid", 32'(outValid), 1);
      chk("single outResult", outResult, 32'h5);
      chk("single outDst", 32'(outDst), 3);
      step();
      chk("single retired outValid", 32'(outValid), 0);
      chk("single retireCount", 32'(retireCount), 1);
      chk("single statusFlags", 32'(statusFlags), 0);

      // backpressure: three ops, two accepted
      outReady = 1'b0;
      offer(32'h11, 5'd1, 1'b0, 3'b000);
      step();
      chk("bp op1 inReady", 32'(inReady), 1);
      offer(32'h22, 5'd2, 1'b0, 3'b000);
      step();
      chk("bp full inReady", 32'(inReady), 0);
      chk("bp head op1", outResult, 32'h11);
      offer(32'h33, 5'd4, 1'b0, 3'b000);
      step();
      chk("bp held inReady", 32'(inReady), 0);
      chk("bp held head", outResult, 32'h11);
      chk("bp held dst", 32'(outDst), 1);
      outReady = 1'b1;
      step();
      chk("bp head op2", outResult, 32'h22);
      chk("bp inReady back", 32'(inReady), 1);
      chk("bp count2", 32'(retireCount), 2);
      step();
      chk("bp head op3", outResult, 32'h33);
      chk("bp op3 dst", 32'(outDst), 4);
      chk("bp count3", 32'(retireCount), 3);
      inValid = 1'b0;
      step();
      chk("bp drained", 32'(outValid), 0);
      chk("bp count4", 32'(retireCount), 4);

      // streaming: ten ops back to back
      for (int i = 0; i < 10; i++) begin
         offer(32'd100 + 32'(i), 5'(i), 1'b0, 3'b000);
         step();
         chk("stream valid", 32'(outValid), 1);
         chk("stream order", outResult, 32'd100 + 32'(i));
      end
      inValid = 1'b0;
      step();
      chk("stream count", 32'(retireCount), 14);
      chk("stream drained", 32'(outValid), 0);

      // flag write enable
      offer(32'h7, 5'd7, 1'b0, 3'b111);
      step();
      inValid = 1'b0;
      step();
      chk("flags held", 32'(statusFlags), 0);
      offer(32'h8, 5'd8, 1'b1, 3'b101);
      step();
      inValid = 1'b0;
      step();
      chk("flags written", 32'(statusFlags), 32'b101);
      chk("flags count", 32'(retireCount), 16);

      // flush from FULL
      outReady = 1'b0;
      offer(32'hA, 5'd10, 1'b1, 3'b010);
      step();
      offer(32'hB, 5'd11, 1'b1, 3'b011);
      step();
      chk("pre-flush inReady", 32'(inReady), 0);
      chk("pre-flush outValid", 32'(outValid), 1);
      flush = 1'b1;
      outReady = 1'b1;
      offer(32'hC, 5'd12, 1'b1, 3'b110);
      step();
      flush = 1'b0;
      inValid = 1'b0;
      chk("flush outValid", 32'(outValid), 0);
      chk("flush inReady", 32'(inReady), 1);
      chk("flush statusFlags", 32'(statusFlags), 32'b101);
      chk("flush count", 32'(retireCount), 16);
      step();
      chk("flush no ghost", 32'(retireCount), 16);

      // async reset while FULL
      outReady = 1'b0;
      offer(32'hD, 5'd13, 1'b0, 3'b000);
      step();
      offer(32'hE, 5'd14, 1'b0, 3'b000);
      step();
      inValid = 1'b0;
      chk("pre-rst full", 32'(inReady), 0);
      #2;
      rst = 1'b0;
      #1;
      chk("arst outValid", 32'(outValid), 0);
      chk("arst inReady", 32'(inReady), 0);
      chk("arst outResult", outResult, 0);
      chk("arst outDst", 32'(outDst), 0);
      chk("arst outRegWrite", 32'(outRegWrite), 0);
      chk("arst statusFlags", 32'(statusFlags), 0);
      chk("arst count", 32'(retireCount), 0);
      @(negedge clk);
      rst = 1'b1;
      outReady = 1'b1;
      step();
      chk("arst release inReady", 32'(inReady), 1);
      chk("arst discarded", 32'(outValid), 0);

      // counter wrap
      for (int i = 0; i < 65535; i++) begin
         offer(32'(i), 5'd1, 1'b0, 3'b000);
         step();
      end
      inValid = 1'b0;
      step();
      chk("wrap max", 32'(retireCount), 32'hFFFF);
      offer(32'h99, 5'd9, 1'b0, 3'b000);
      step();
      inValid = 1'b0;
      step();
      chk("wrap zero", 32'(retireCount), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", numChk, numBad);
      $finish;
   end

endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, the width of the result path.
REQ-002 SHALL have parameter REG_W, default 5, the width of the destination register index.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port flush, input, 1 bit: synchronous pipeline flush.
REQ-006 SHALL have port inValid, input, 1 bit: the upstream ALU holds a valid operation.
REQ-007 SHALL have port inReady, output, 1 bit: the stage can accept an operation this cycle.
REQ-008 SHALL have port result, input, DATA_W bits: the ALU result.
REQ-009 SHALL have ports carryFlag, signFlag and zeroFlag, each input, 1 bit: the ALU flags.
REQ-010 SHALL have port dstReg, input, REG_W bits: the write-back register index.
REQ-011 SHALL have port regWrite, input, 1 bit: the operation writes dstReg.
REQ-012 SHALL have port flagWrite, input, 1 bit: the operation updates the architectural flags.
REQ-013 SHALL have port outValid, output, 1 bit: the head entry is valid.
REQ-014 SHALL have port outReady, input, 1 bit: the downstream stage accepts the head entry.
REQ-015 SHALL have ports outResult (DATA_W), outDst (REG_W) and outRegWrite (1), all outputs: the head entry fields.
REQ-016 SHALL have port statusFlags, output, 3 bits {carry, sign, zero}: the architectural flag register.
REQ-017 SHALL have port retireCount, output, 16 bits: the count of entries retired downstream.

Function
REQ-018 SHALL capture an entry (all input fields) on any cycle with inValid && inReady && !flush.
REQ-019 SHALL retire the head entry on any cycle with outValid && outReady && !flush.
REQ-020 SHALL buffer entries in a 2-entry skid buffer (head + skid) governed by FSM states EMPTY, ONE and FULL.
REQ-021 SHALL transition EMPTY->ONE on capture; the captured entry becomes the head, visible on outputs the next cycle (latency 1).
REQ-022 SHALL stay in ONE on simultaneous capture and retire; the new entry replaces the head.
REQ-023 SHALL transition ONE->EMPTY on retire without capture, and ONE->FULL on capture without retire; the new entry goes to the skid slot.
REQ-024 SHALL transition FULL->ONE on retire; the skid entry moves to the head the same edge; no capture occurs in FULL.
REQ-025 SHALL drive inReady as a registered signal, equal to 1 exactly when the state is not FULL; no combinational path from outReady to inReady.
REQ-026 SHALL drive outValid as 1 in ONE and FULL; head fields SHALL hold stable while outValid && !outReady.
REQ-027 SHALL update statusFlags to the retiring head's {carry, sign, zero} on each retire whose flagWrite=1, and otherwise hold them.
REQ-028 SHALL increment retireCount by 1 per retire, wrapping from 0xFFFF to 0x0000.
REQ-029 SHALL, on flush, go to EMPTY and discard both entries and any same-cycle capture or retire; statusFlags and retireCount SHALL remain unchanged.
REQ-030 SHALL treat input fields as don't-care when inValid=0; they SHALL NOT affect state.

Reset
REQ-031 SHALL, while rst=0, immediately force state EMPTY, outValid=0, inReady=0, outResult=0, outDst=0, outRegWrite=0, statusFlags=3'b000 and retireCount=0.
REQ-032 SHALL drive inReady=1 on the first rising clk edge after rst deasserts; reset mid-transfer SHALL discard all buffered entries.

Verification
REQ-033 Bench SHALL check: a single op (result=0x0000_0005, dstReg=3, flagWrite=1, flags=000) with outReady=1 -> outValid=1 next cycle, outResult=5, outDst=3; after retire statusFlags=000, retireCount=1.
REQ-034 Bench SHALL check: outReady=0 with 3 ops offered on consecutive cycles -> ops 1 and 2 accepted, inReady=0 from cycle 3; op 3 is held upstream; outputs show op 1 until outReady=1.
REQ-035 Bench SHALL check: continuous inValid=outReady=1 for 10 ops -> one op retired per cycle after 1-cycle latency, in order; retireCount=10.
REQ-036 Bench SHALL check: a FULL buffer, then flush=1 with inValid=1 -> next cycle outValid=0, inReady=1, statusFlags and retireCount unchanged.
REQ-037 Bench SHALL check: retire of an op with flagWrite=0 and flags=111 -> statusFlags unchanged; then an op with flagWrite=1 and flags=101 -> statusFlags=101.
REQ-038 Bench SHALL check: rst asserted asynchronously mid-cycle while FULL -> outputs reach reset values before the next edge; retireCount pre-set near 0xFFFF wraps to 0 after a further retire.
